// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Every fetch queue entry carries its own PC so decode never has to reconstruct it.
package fetch_prefetch_unit_pkg;

    localparam int PC_W    = 9;
    localparam int INS_W   = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries with a flush for redirects.
// Read/write pointers carry an extra wrap bit so that full and empty can be told apart.
module fetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int DEPTH_P = DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  fetch_entry_t                   i_push_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output fetch_entry_t                   o_head,
    output logic                           o_empty,
    output logic                           o_full,
    output logic [$clog2(DEPTH_P+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH_P);

    fetch_entry_t r_mem [DEPTH_P];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Flush wins over any push or pop issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests and
// buffers returned words for IF/ID, dropping responses made stale by EX redirects.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic             o_imem_req_valid,
    input  logic             i_imem_req_ready,
    output logic [PC_W-1:0]  o_imem_req_addr,
    input  logic             i_imem_rsp_valid,
    input  logic [INS_W-1:0] i_imem_rsp_data,
    input  logic             i_redirect,
    input  logic [PC_W-1:0]  i_redirect_pc,
    input  logic             i_id_stall,
    output logic             o_if_valid,
    output logic [INS_W-1:0] o_if_instr,
    output logic [PC_W-1:0]  o_if_pc,
    output logic [OCC_W-1:0] o_occupancy
);

    localparam int INFL_W = CNT_W + 1;
    localparam int FILL_W = OCC_W + 1;

    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_resp_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard;

    logic [PC_W-1:0]   w_redirect_pc;
    logic [INFL_W-1:0] w_in_flight;
    logic [FILL_W-1:0] w_fill;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [OCC_W-1:0]  w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;

    assign w_redirect_pc = alignPc(i_redirect_pc);
    assign w_in_flight   = INFL_W'(r_outstanding) + INFL_W'(r_discard);
    assign w_fill        = FILL_W'(w_count) + FILL_W'(r_outstanding);

    // Credit counts words already queued plus words still owed by memory; a pop this cycle
    // does not free a slot until next cycle, which keeps the issue path off the pop path.
    assign o_imem_req_valid = !reset && !i_redirect
                            && (w_in_flight < INFL_W'(MAX_OUT))
                            && (w_fill < FILL_W'(DEPTH));
    assign w_accept     = o_imem_req_valid && i_imem_req_ready;
    assign w_push       = i_imem_rsp_valid && !i_redirect && (r_discard == '0);
    assign w_pop        = !w_fifo_empty && !i_id_stall && !i_redirect;
    assign w_push_entry = '{pc: r_resp_pc, instr: i_imem_rsp_data};

    // On redirect every in-flight request becomes stale; the one answering this cycle is already gone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (i_redirect) begin
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_outstanding <= '0;
            r_discard     <= r_discard + r_outstanding - CNT_W'(i_imem_rsp_valid);
        end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_push)   r_resp_pc  <= r_resp_pc + PC_STEP;
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_push);
            if (i_imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
        end
    end

    fetch_fifo #(
        .DEPTH_P (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) assert (!(w_push && w_fifo_full));
    end

    assign o_imem_req_addr = reset ? '0 : r_fetch_pc;
    assign o_if_valid      = !reset && !w_fifo_empty;
    assign o_if_pc         = o_if_valid ? w_head.pc : '0;
    assign o_if_instr      = o_if_valid ? w_head.instr : '0;
    assign o_occupancy     = reset ? '0 : w_count;

endmodule
